// File: rtl/approx_adder_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// approx_adder_pipe : two-stage approximate adder, OR-approximated LSBs with a
// Kogge-Stone upper sum. Error monitor built only with APPROX_ERR_MON_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
module approx_adder_pipe #(
  parameter int W     = 16,
  parameter int P_MAX = 8,
  parameter int LW    = (P_MAX < 1) ? 1 : $clog2(P_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [LW-1:0] approx_lvl,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W:0]    y,
  input  logic          err_clr,
  output logic [31:0]   err_cnt,
  output logic [31:0]   err_sum,
  output logic [W:0]    err_max
);

  localparam int            C_LEVELS = (W <= 1) ? 1 : $clog2(W);
  localparam logic [LW-1:0] C_PMAX   = LW'(P_MAX);

  logic          r_s1_valid;
  logic [W-1:0]  r_s1_a;
  logic [W-1:0]  r_s1_b;
  logic [LW-1:0] r_s1_k;
  logic          r_out_valid;
  logic [W:0]    r_y;

  logic [LW-1:0] w_k;
  logic          w_s2_adv;
  logic [W-1:0]  w_g;
  logic [W-1:0]  w_p;
  logic [W-1:0]  w_lo;
  logic [W-1:0]  w_gk;
  logic [W-1:0]  w_pk;
  logic [W:0]    w_c;
  logic [W:0]    w_y;

  assign w_k      = (approx_lvl > C_PMAX) ? C_PMAX : approx_lvl;
  assign w_s2_adv = !r_out_valid || out_ready;
  assign in_ready = !r_s1_valid || w_s2_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_k     <= '0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a <= a;
        r_s1_b <= b;
        r_s1_k <= w_k;
      end
    end
  end

  // Below bit k-1 g/p are zero so the prefix network sees only the injected
  // carry a[k-1]&b[k-1] and the exact generate/propagate of bits k..W-1.
  always_comb begin
    w_g  = '0;
    w_p  = '0;
    w_lo = '0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(r_s1_k)) begin
        w_lo[i] = r_s1_a[i] | r_s1_b[i];
        if (i == int'(r_s1_k) - 1) begin
          w_g[i] = r_s1_a[i] & r_s1_b[i];
        end
      end else begin
        w_g[i] = r_s1_a[i] & r_s1_b[i];
        w_p[i] = r_s1_a[i] ^ r_s1_b[i];
      end
    end
  end

  always_comb begin
    w_gk = w_g;
    w_pk = w_p;
    for (int l = 0; l < C_LEVELS; l++) begin
      w_gk = w_gk | (w_pk & (w_gk << (1 << l)));
      w_pk = w_pk & (w_pk << (1 << l));
    end
  end

  assign w_c = {w_gk, 1'b0};
  assign w_y = {w_c[W], (w_p ^ w_c[W-1:0]) | w_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_y         <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_y <= w_y;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;

`ifdef APPROX_ERR_MON_EN
  logic [W:0]  r_exact;
  logic [31:0] r_err_cnt;
  logic [31:0] r_err_sum;
  logic [W:0]  r_err_max;
  logic        w_retire;
  logic [W:0]  w_diff;
  logic [32:0] w_sum_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_exact <= '0;
    end else if (w_s2_adv && r_s1_valid) begin
      r_exact <= {1'b0, r_s1_a} + {1'b0, r_s1_b};
    end
  end

  assign w_retire  = r_out_valid && out_ready;
  assign w_diff    = (r_exact >= r_y) ? (r_exact - r_y) : (r_y - r_exact);
  assign w_sum_ext = {1'b0, r_err_sum} + 33'(w_diff);

  // A clear in the retire cycle drops that result's contribution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
      r_err_sum <= '0;
      r_err_max <= '0;
    end else if (w_retire && (w_diff != '0)) begin
      r_err_cnt <= (r_err_cnt == 32'hFFFF_FFFF) ? r_err_cnt : r_err_cnt + 32'd1;
      r_err_sum <= w_sum_ext[32] ? 32'hFFFF_FFFF : w_sum_ext[31:0];
      if (w_diff > r_err_max) begin
        r_err_max <= w_diff;
      end
    end
  end

  assign err_cnt = r_err_cnt;
  assign err_sum = r_err_sum;
  assign err_max = r_err_max;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign err_cnt          = '0;
  assign err_sum          = '0;
  assign err_max          = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_pipe.sv
`default_nettype none
// Scoreboard bench for approx_adder_pipe (W=6, P_MAX=2); error statistics are
// expected only when APPROX_ERR_MON_EN is defined.
module tb_approx_adder_pipe;
  localparam int W     = 6;
  localparam int P_MAX = 2;
  localparam int LW    = 2;

  typedef struct {
    logic [W:0] y;
    int         exact;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [LW-1:0] approx_lvl;
  logic          out_valid;
  logic          out_ready;
  logic [W:0]    y;
  logic          err_clr;
  logic [31:0]   err_cnt;
  logic [31:0]   err_sum;
  logic [W:0]    err_max;

  int     n_checks  = 0;
  int     n_fail    = 0;
  int     n_retired = 0;
  exp_t   exp_q[$];
  exp_t   e_mon;
  longint m_cnt = 0;
  longint m_sum = 0;
  longint m_max = 0;
  logic   blocked;
  logic   rnd_done;

  always #5 clk = ~clk;

  approx_adder_pipe #(.W(W), .P_MAX(P_MAX), .LW(LW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .approx_lvl(approx_lvl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
    .err_sum   (err_sum),
    .err_max   (err_max)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [W:0] model_y(input int av, input int bv, input int lv);
    int k, lo, cin, hi, t;
    logic [W:0] r;
    k   = (lv > P_MAX) ? P_MAX : lv;
    lo  = (av | bv) & ((1 << k) - 1);
    cin = (k > 0) ? ((av >> (k - 1)) & (bv >> (k - 1)) & 1) : 0;
    hi  = (av >> k) + (bv >> k) + cin;
    t   = (hi << k) | lo;
    r   = t[W:0];
    return r;
  endfunction

  // Drive one beat (callable at or just after a negedge); returns at the
  // negedge following acceptance.
  task automatic send(input int av, input int bv, input int lv);
    int   guard;
    exp_t e;
    guard      = 0;
    a          = av[W-1:0];
    b          = bv[W-1:0];
    approx_lvl = lv[LW-1:0];
    in_valid   = 1'b1;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!in_ready) begin
      chk("send_timeout", in_ready, 1);
    end else begin
      e.y     = model_y(av, bv, lv);
      e.exact = av + bv;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() != 0) chk({tag, "_drain"}, exp_q.size(), 0);
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_err_cnt"}, err_cnt, m_cnt);
    chk({tag, "_err_sum"}, err_sum, m_sum);
    chk({tag, "_err_max"}, err_max, m_max);
  endtask

  task automatic lat_check(input string tag, input int av, input int bv, input int lv,
                           input int exp_y);
    int n;
    send(av, bv, lv);
    n = 1;
    #1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, 2);
    chk({tag, "_y"}, y, exp_y);
  endtask

  // Scoreboard: pops on the cycle a result will retire.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      m_cnt = 0;
      m_sum = 0;
      m_max = 0;
    end else begin
`ifdef APPROX_ERR_MON_EN
      longint d;
      d = 0;
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", exp_q.size(), 1);
        end else begin
          e_mon = exp_q.pop_front();
          chk("y", y, e_mon.y);
          n_retired++;
`ifdef APPROX_ERR_MON_EN
          d = (e_mon.exact > int'(e_mon.y)) ? e_mon.exact - int'(e_mon.y)
                                            : int'(e_mon.y) - e_mon.exact;
`endif
        end
      end
`ifdef APPROX_ERR_MON_EN
      if (err_clr) begin
        m_cnt = 0;
        m_sum = 0;
        m_max = 0;
      end else if (d != 0) begin
        m_cnt = (m_cnt == 64'hFFFF_FFFF) ? m_cnt : m_cnt + 1;
        m_sum = (m_sum + d > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum + d;
        if (d > m_max) m_max = d;
      end
`endif
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst        = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    approx_lvl = '0;
    out_ready  = 1'b1;
    err_clr    = 1'b0;
    blocked    = 1'b0;
    rnd_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y", y, 0);
    chk_stats("rst");
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    lat_check("req35", 3, 3, 2, 7);
    drain("req35");
    chk_stats("req35");
`ifdef APPROX_ERR_MON_EN
    chk("req35_cnt_abs", err_cnt, 1);
    chk("req35_max_abs", err_max, 1);
`endif

    send(63, 1, 2);
    send(63, 1, 0);
    drain("req36");
    chk_stats("req36");

    lat_check("req37", 3, 3, 3, 7);
    drain("req37");

    base = n_retired;
    fork
      begin
        for (int i = 0; i < 10; i++) send((i * 5) % 64, (i * 7 + 3) % 64, i % 4);
      end
      begin
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        repeat (4) @(negedge clk);
        out_ready = 1'b1;
      end
      begin
        repeat (12) begin
          @(negedge clk);
          #1;
          if (in_valid && !in_ready) blocked = 1'b1;
        end
      end
    join
    drain("req38");
    chk("req38_in_ready_drop", blocked, 1);
    chk("req38_count", n_retired - base, 10);
    chk_stats("req38");

    base = n_retired;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          int ra, rb, rl;
          ra = int'($urandom_range(0, 63));
          rb = int'($urandom_range(0, 63));
          rl = int'($urandom_range(0, 3));
          send(ra, rb, rl);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain("rand");
    chk("rand_count", n_retired - base, 30);
    chk_stats("rand");

    send(5, 6, 1);
    send(7, 9, 2);
    #3;
    rst = 1'b1;
    #1;
    exp_q.delete();
    chk("req39_out_valid", out_valid, 0);
    chk("req39_y", y, 0);
    chk("req39_err_cnt", err_cnt, 0);
    chk("req39_err_sum", err_sum, 0);
    chk("req39_err_max", err_max, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("req39_in_ready", in_ready, 1);
    lat_check("req39", 10, 20, 1, 30);
    drain("req39");

    begin
      int g;
      out_ready = 1'b0;
      send(3, 3, 2);
      g = 0;
      #1;
      while (!out_valid && g < 10) begin
        @(negedge clk);
        #1;
        g++;
      end
      chk("req40_wait_out_valid", out_valid, 1);
      err_clr   = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      #1;
      chk("req40_clr_cnt", err_cnt, 0);
      chk_stats("req40_clr");
    end

`ifdef APPROX_ERR_MON_EN
    @(negedge clk);
    force dut.r_err_sum = 32'hFFFF_FFFE;
    #1;
    release dut.r_err_sum;
    m_sum = 64'hFFFF_FFFE;
    send(3, 3, 2);
    send(3, 3, 2);
    drain("req40_sat");
    chk("req40_sat_sum", err_sum, 64'hFFFF_FFFF);
    chk_stats("req40_sat");
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/approx_adder_pipe.md
APPROX_ADDER_PIPE -- requirements
Module: approx_adder_pipe

Interface
REQ-001 SHALL have parameter W, default 16: operand width in bits, legal range 2..32.
REQ-002 SHALL have parameter P_MAX, default 8: maximum number of approximated LSBs, legal range 0..W-1.
REQ-003 SHALL have parameter LW, default $clog2(P_MAX+1) (minimum 1): width of approx_lvl.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port in_valid, input, 1: operand beat valid.
REQ-007 SHALL have port in_ready, output, 1: block accepts a beat this cycle.
REQ-008 SHALL have port a, input, W: operand A.
REQ-009 SHALL have port b, input, W: operand B.
REQ-010 SHALL have port approx_lvl, input, LW: number k of approximated LSBs for this beat.
REQ-011 SHALL have port out_valid, output, 1: result valid.
REQ-012 SHALL have port out_ready, input, 1: downstream accepts the result.
REQ-013 SHALL have port y, output, W+1: the approximate sum.
REQ-014 SHALL have port err_clr, input, 1: single-cycle clear of the error statistics.
REQ-015 SHALL have port err_cnt, output, 32: count of results that differ from the exact sum.
REQ-016 SHALL have port err_sum, output, 32: accumulated absolute error.
REQ-017 SHALL have port err_max, output, W+1: largest absolute error seen.

Function
REQ-018 SHALL accept a beat when in_valid && in_ready, sampling a, b and approx_lvl together.
REQ-019 SHALL use k = min(approx_lvl, P_MAX) per beat; approx_lvl values above P_MAX saturate to P_MAX.
REQ-020 SHALL compute approximate bits for i<k as y[i] = a[i] | b[i].
REQ-021 SHALL use carry into bit k equal to a[k-1] & b[k-1] when k>0, and 0 when k=0.
REQ-022 SHALL compute bits k..W-1 as an exact carry-lookahead sum, with y[W] = the final carry out.
REQ-023 SHALL be a two-stage pipeline: stage 1 registers the operands and k; stage 2 registers y; latency from acceptance to out_valid is 2 cycles when there is no stall.
REQ-024 SHALL advance a stage only if it is empty or the stage after it advances this cycle; in_ready = !s1_valid || s2_advance, where s2_advance = !out_valid || out_ready.
REQ-025 SHALL sustain 1 beat/cycle with out_ready held high; with out_ready low, y and out_valid SHALL hold, and no beat SHALL be lost or duplicated.
REQ-026 SHALL retire a result only on out_valid && out_ready.
REQ-027 SHALL add no combinational path from in_valid to out_valid; the in_ready path from out_ready is combinational.

Reset
REQ-028 SHALL, while rst is high, clear s1_valid and out_valid, set y=0, and set err_cnt, err_sum and err_max to 0, asynchronously.
REQ-029 SHALL discard any in-flight beats when reset is asserted mid-operation, and in_ready SHALL read 1 in the first cycle after rst is released.

Configuration
REQ-030 SHALL implement the error monitor only when macro APPROX_ERR_MON_EN is defined.
REQ-031 With APPROX_ERR_MON_EN: at each retired result, d = |exact(a+b) - y|; if d != 0, increment err_cnt, add d to err_sum, and update err_max = max(err_max, d).
REQ-032 With APPROX_ERR_MON_EN: err_cnt and err_sum SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-033 With APPROX_ERR_MON_EN: if err_clr coincides with a retire, the clear wins and that result's contribution is dropped.
REQ-034 Without APPROX_ERR_MON_EN: no exact adder is built, err_clr is ignored, and err_cnt, err_sum and err_max are tied to 0.

Verification (W=6, P_MAX=2 unless stated)
REQ-035 a=3, b=3, lvl=2 -> y=7 two cycles later; err_cnt=1, err_sum=1, err_max=1.
REQ-036 a=63, b=1, lvl=2 -> y=63; a=63, b=1, lvl=0 -> y=64 with the error statistics unchanged.
REQ-037 lvl=3 (above P_MAX), a=3, b=3 -> behaves as k=2, y=7.
REQ-038 10 back-to-back beats, with out_ready low for cycles 3-6 -> in_ready drops after 2 beats are buffered; all 10 results emerge in order with none lost.
REQ-039 rst pulse while 2 beats are in flight -> out_valid=0 and all counters=0; the next beat completes with 2-cycle latency.
REQ-040 err_clr asserted in the same cycle as a retire with d=1 -> err_cnt=0 the next cycle; a saturation test preloading err_sum near max -> the value holds at 0xFFFFFFFF.
